// File: rtl/pc_pkg.sv
// Shared PC word channel types, code constants and stream index map.
package pc_pkg;

  localparam int PC_CODE_W = 8;
  localparam int PC_DATA_W = 24;

  typedef struct packed {
    logic [PC_CODE_W-1:0] code;
    logic [PC_DATA_W-1:0] payload;
  } pc_word_t;

  localparam logic [PC_CODE_W-1:0] HB_CODE = 8'd13;
  localparam logic [PC_CODE_W-1:0] SF_CODE = 8'd14;

  localparam int HB_IDX = 0;
  localparam int SF_IDX = 1;

endpackage

// File: rtl/pc_msg_arbiter_rr_pick.sv
// First set request at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic hit;
    int   j;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      for (int i = 0; i < N; i++) begin
        if (!hit && i == j && req[i]) begin
          hit = 1'b1;
          idx = IW'(i);
        end
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/pc_msg_arbiter.sv
// Message-locked round-robin merge onto the PC word channel.
// Build option: PC_ARB_HB_PRIO_EN gives stream 0 priority between messages.
module pc_msg_arbiter
  import pc_pkg::*;
#(
  parameter int NIN     = 2,
  parameter int NPCcode = PC_CODE_W,
  parameter int NPCdata = PC_DATA_W,
  localparam int W  = NPCcode + NPCdata,
  localparam int IW = (NIN > 1) ? $clog2(NIN) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NIN*W-1:0]   in_d,
  input  logic [NIN-1:0]     in_v,
  input  logic [NIN-1:0]     in_last,
  output logic [NIN-1:0]     in_a,
  output logic [NPCcode-1:0] out_code,
  output logic [NPCdata-1:0] out_payload,
  output logic               out_v,
  input  logic               out_a,
  output logic [IW-1:0]      grant_idx,
  output logic               locked
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]         r_state;
  logic [IW-1:0]      r_rr_ptr;
  logic [IW-1:0]      r_grant;
  logic               r_prio;
  logic               r_out_v;
  logic [NPCcode-1:0] r_out_code;
  logic [NPCdata-1:0] r_out_payload;

  logic           w_slot_free;
  logic [NIN-1:0] w_in_a;
  logic [W-1:0]   w_word;
  logic           w_xfer;
  logic           w_last;
  logic [IW-1:0]  w_pick;
  logic           w_any;
  logic           w_prio;
  logic [IW-1:0]  w_rr_next;

  rr_pick #(
    .N  (NIN),
    .IW (IW)
  ) u_pick (
    .req (in_v),
    .ptr (r_rr_ptr),
    .idx (w_pick),
    .any (w_any)
  );

`ifdef PC_ARB_HB_PRIO_EN
  assign w_prio = in_v[HB_IDX];
`else
  assign w_prio = 1'b0;
`endif

  assign w_slot_free = !r_out_v || out_a;

  // Ack is a function of registers and slot_free only, never of in_v.
  always_comb begin
    w_in_a = '0;
    w_word = '0;
    for (int i = 0; i < NIN; i++) begin
      if (r_grant == IW'(i)) begin
        w_word = in_d[i*W +: W];
        if (r_state == ST_LOCKED) w_in_a[i] = w_slot_free;
      end
    end
  end

  assign w_xfer = |(w_in_a & in_v);
  assign w_last = |(w_in_a & in_v & in_last);

  assign w_rr_next = (r_grant == IW'(NIN-1)) ? '0 : r_grant + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_prio        <= 1'b0;
      r_out_v       <= 1'b0;
      r_out_code    <= '0;
      r_out_payload <= '0;
    end else begin
      if (w_xfer) begin
        r_out_code    <= w_word[W-1 -: NPCcode];
        r_out_payload <= w_word[NPCdata-1:0];
        r_out_v       <= 1'b1;
      end else if (out_a) begin
        r_out_v <= 1'b0;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_LOCKED;
            r_grant <= w_prio ? IW'(HB_IDX) : w_pick;
            r_prio  <= w_prio;
          end
        end
        ST_LOCKED: begin
          if (w_last) begin
            r_state <= ST_IDLE;
            if (!r_prio) r_rr_ptr <= w_rr_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_a        = w_in_a;
  assign out_v       = r_out_v;
  assign out_code    = r_out_code;
  assign out_payload = r_out_payload;
  assign locked      = (r_state == ST_LOCKED);
  assign grant_idx   = locked ? r_grant : '0;

endmodule

// File: tb/tb_pc_msg_arbiter.sv
// Directed bench for pc_msg_arbiter (NIN=2, HB=0, SF=1).
module tb_pc_msg_arbiter;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_d;
  logic [1:0]  in_v;
  logic [1:0]  in_last;
  logic [1:0]  in_a;
  logic [7:0]  out_code;
  logic [23:0] out_payload;
  logic        out_v;
  logic        out_a;
  logic [0:0]  grant_idx;
  logic        locked;

  int n_pass = 0;
  int n_tot  = 0;
  logic [7:0] exp_c2;

  pc_msg_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .in_d        (in_d),
    .in_v        (in_v),
    .in_last     (in_last),
    .in_a        (in_a),
    .out_code    (out_code),
    .out_payload (out_payload),
    .out_v       (out_v),
    .out_a       (out_a),
    .grant_idx   (grant_idx),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] o,
                     input logic [31:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  task automatic setw(input int i, input logic [7:0] c,
                      input logic [23:0] p,
                      input logic v, input logic l);
    pc_word_t w;
    w.code = c;
    w.payload = p;
    in_d[i*32 +: 32] = w;
    in_v[i] = v;
    in_last[i] = l;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] c,
                         input logic [23:0] p);
    chk({tag, ".v"}, 32'(out_v), 32'd1);
    chk({tag, ".code"}, 32'(out_code), 32'(c));
    chk({tag, ".pay"}, 32'(out_payload), 32'(p));
  endtask

  initial begin
    reset = 1'b1;
    in_d = '0;
    in_v = '0;
    in_last = '0;
    out_a = 1'b1;
    #2;
    chk("rst.out_v", 32'(out_v), 0);
    chk("rst.locked", 32'(locked), 0);
    chk("rst.in_a", 32'(in_a), 0);
    chk("rst.gidx", 32'(grant_idx), 0);
    chk("rst.code", 32'(out_code), 0);
    chk("rst.pay", 32'(out_payload), 0);
    tick();
    tick();
    reset = 1'b0;

    // single SF message
    setw(SF_IDX, SF_CODE, 24'h000001, 1'b1, 1'b0);
    tick();
    chk("t1.locked", 32'(locked), 1);
    chk("t1.gidx", 32'(grant_idx), 1);
    chk("t1.bubble", 32'(out_v), 0);
    chk("t1.in_a", 32'(in_a), 2);
    tick();
    chk_out("t1.w1", SF_CODE, 24'h000001);
    setw(SF_IDX, SF_CODE, 24'h000002, 1'b1, 1'b0);
    tick();
    chk_out("t1.w2", SF_CODE, 24'h000002);
    setw(SF_IDX, SF_CODE, 24'h000003, 1'b1, 1'b1);
    tick();
    chk_out("t1.w3", SF_CODE, 24'h000003);
    chk("t1.unlock", 32'(locked), 0);
    in_v = '0;
    tick();
    chk("t1.idle_v", 32'(out_v), 0);

    // contention: HB then SF, no interleave
    setw(HB_IDX, HB_CODE, 24'h0000A1, 1'b1, 1'b0);
    setw(SF_IDX, SF_CODE, 24'h0000B1, 1'b1, 1'b0);
    tick();
    chk("t2.gidx0", 32'(grant_idx), 0);
    chk("t2.in_a0", 32'(in_a), 1);
    tick();
    chk_out("t2.hb1", HB_CODE, 24'h0000A1);
    setw(HB_IDX, HB_CODE, 24'h0000A2, 1'b1, 1'b1);
    tick();
    chk_out("t2.hb2", HB_CODE, 24'h0000A2);
    chk("t2.unlock0", 32'(locked), 0);
    in_v[HB_IDX] = 1'b0;
    tick();
    chk("t2.gidx1", 32'(grant_idx), 1);
    chk("t2.in_a1", 32'(in_a), 2);
    chk("t2.bubble", 32'(out_v), 0);
    tick();
    chk_out("t2.sf1", SF_CODE, 24'h0000B1);
    setw(SF_IDX, SF_CODE, 24'h0000B2, 1'b1, 1'b0);
    setw(HB_IDX, HB_CODE, 24'h0000A3, 1'b1, 1'b1);
    tick();
    chk_out("t2.sf2", SF_CODE, 24'h0000B2);
    chk("t2.hb_wait", 32'(in_a), 2);
    setw(SF_IDX, SF_CODE, 24'h0000B3, 1'b1, 1'b1);
    tick();
    chk_out("t2.sf3", SF_CODE, 24'h0000B3);
    in_v = '0;
    tick();

    // fairness with one-word messages
`ifdef PC_ARB_HB_PRIO_EN
    exp_c2 = HB_CODE;
`else
    exp_c2 = SF_CODE;
`endif
    setw(HB_IDX, HB_CODE, 24'h0000C0, 1'b1, 1'b1);
    setw(SF_IDX, SF_CODE, 24'h0000D0, 1'b1, 1'b1);
    tick();
    tick();
    chk("t3.m1", 32'(out_code), 32'(HB_CODE));
    tick();
    chk("t3.gap", 32'(out_v), 0);
    tick();
    chk("t3.m2", 32'(out_code), 32'(exp_c2));
    tick();
    tick();
    chk("t3.m3", 32'(out_code), 32'(HB_CODE));
    tick();
    tick();
    chk("t3.m4", 32'(out_code), 32'(exp_c2));
    in_v = '0;
    tick();
    chk("t3.idle", 32'(locked), 0);

    // backpressure
    setw(SF_IDX, SF_CODE, 24'h000010, 1'b1, 1'b0);
    tick();
    chk("t4.gidx", 32'(grant_idx), 1);
    tick();
    chk_out("t4.w1", SF_CODE, 24'h000010);
    setw(SF_IDX, SF_CODE, 24'h000011, 1'b1, 1'b0);
    out_a = 1'b0;
    #1;
    chk("t4.stall_a", 32'(in_a), 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out("t4.hold", SF_CODE, 24'h000010);
      chk("t4.hold_a", 32'(in_a), 0);
    end
    out_a = 1'b1;
    #1;
    chk("t4.rel_a", 32'(in_a), 2);
    tick();
    chk_out("t4.w2", SF_CODE, 24'h000011);
    setw(SF_IDX, SF_CODE, 24'h000012, 1'b1, 1'b1);
    tick();
    chk_out("t4.w3", SF_CODE, 24'h000012);
    chk("t4.unlock", 32'(locked), 0);
    in_v = '0;
    tick();
    chk("t4.idle_v", 32'(out_v), 0);

    // granted SF stalls while HB waits
    setw(SF_IDX, SF_CODE, 24'h000020, 1'b1, 1'b0);
    tick();
    chk("t5.gidx", 32'(grant_idx), 1);
    tick();
    chk_out("t5.w1", SF_CODE, 24'h000020);
    in_v[SF_IDX] = 1'b0;
    setw(HB_IDX, HB_CODE, 24'h0000EE, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5.lock", 32'(locked), 1);
      chk("t5.gidx_s", 32'(grant_idx), 1);
      chk("t5.in_a", 32'(in_a), 2);
    end
    chk("t5.drain", 32'(out_v), 0);
    setw(SF_IDX, SF_CODE, 24'h000021, 1'b1, 1'b1);
    tick();
    chk_out("t5.w2", SF_CODE, 24'h000021);
    chk("t5.unlock", 32'(locked), 0);
    in_v[SF_IDX] = 1'b0;
    tick();
    chk("t5.hb_gnt", 32'(grant_idx), 0);
    tick();
    chk_out("t5.hb", HB_CODE, 24'h0000EE);
    in_v = '0;
    tick();

    // async reset between word 2 and word 3
    setw(SF_IDX, SF_CODE, 24'h000030, 1'b1, 1'b0);
    tick();
    tick();
    chk_out("t6.w1", SF_CODE, 24'h000030);
    setw(SF_IDX, SF_CODE, 24'h000031, 1'b1, 1'b0);
    tick();
    chk_out("t6.w2", SF_CODE, 24'h000031);
    setw(SF_IDX, SF_CODE, 24'h000032, 1'b1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6.out_v", 32'(out_v), 0);
    chk("t6.in_a", 32'(in_a), 0);
    chk("t6.locked", 32'(locked), 0);
    chk("t6.code", 32'(out_code), 0);
    tick();
    reset = 1'b0;
    setw(HB_IDX, HB_CODE, 24'h000050, 1'b1, 1'b1);
    setw(SF_IDX, SF_CODE, 24'h000040, 1'b1, 1'b1);
    tick();
    chk("t6.rr0", 32'(grant_idx), 0);
    tick();
    chk_out("t6.hb", HB_CODE, 24'h000050);
    in_v = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
